// File: rtl/rf_pkg.sv
// Shared constants and types for the parametrised register file.
// Optional feature macro: RF_BYPASS_EN (write-to-read bypass on q).
package rf_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_RD_DEF = 2;

   // Register 0 is hardwired to zero and never marked busy.
   localparam int REG_ZERO   = 0;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/regfile_sb.sv
// Per-register busy scoreboard. A set strobe (issue) marks the destination
// busy; a clear strobe (writeback) releases it. When both target the same
// register in one edge the set wins, since a new producer is now pending.
// Register 0 is never marked busy.
module regfile_sb
   import rf_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic                 set_en,
   input  logic [ADDR_W-1:0]    set_a,
   input  logic                 clr_en,
   input  logic [ADDR_W-1:0]    clr_a,
   output logic [2**ADDR_W-1:0] busy
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Next busy vector: clear first, then set, so a same-edge set dominates.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) begin
         busy_d[clr_a] = 1'b0;
      end
      if (set_en) begin
         busy_d[set_a] = 1'b1;
      end
      busy_d[REG_ZERO] = 1'b0;
   end

   // Busy register with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: rtl/regfile_nr_sb.sv
// Parametrised register file with N read ports, a busy scoreboard for hazard
// detection and an addressable debug read port. Register 0 reads as zero.
// Optional feature macro: RF_BYPASS_EN. When defined, a read of the register
// being written in the same cycle returns the write data and reports not-busy;
// otherwise reads see the pre-edge contents and the raw busy bit.
// The debug port is never bypassed.
module regfile_nr_sb
   import rf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = NUM_RD_DEF
) (
   input  logic                     clk,
   input  logic                     clr_n,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wa,
   input  logic [DATA_W-1:0]        wd,
   input  logic [NUM_RD*ADDR_W-1:0] ra,
   output logic [NUM_RD*DATA_W-1:0] q,
   output logic [NUM_RD-1:0]        rbusy,
   input  logic                     iss_vld,
   input  logic [ADDR_W-1:0]        iss_rd,
   input  logic [ADDR_W-1:0]        dbg_a,
   output logic [DATA_W-1:0]        dbg_q
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wr_hit;
   logic [ADDR_W-1:0] ra_k;

   // A write only lands when it targets a real (non-zero) register.
   assign wr_hit = we && (wa != ADDR_W'(REG_ZERO));

   // Next storage contents: apply the single write port, keep r0 at zero.
   always_comb begin
      mem_d = mem_q;
      if (wr_hit) begin
         mem_d[wa] = wd;
      end
      mem_d[REG_ZERO] = '0;
   end

   // Storage array with synchronous active-low clear; reset drops any write.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!clr_n) begin
            mem_q[i] <= '0;
         end else begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   regfile_sb #(
      .ADDR_W (ADDR_W)
   ) u_sb (
      .clk    (clk),
      .clr_n  (clr_n),
      .set_en (iss_vld),
      .set_a  (iss_rd),
      .clr_en (we),
      .clr_a  (wa),
      .busy   (busy)
   );

   // Read ports: storage lookup, optionally overridden by the in-flight write.
   always_comb begin
      q     = '0;
      rbusy = '0;
      ra_k  = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra_k = ra[k*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
         if (wr_hit && (ra_k == wa)) begin
            q[k*DATA_W +: DATA_W] = wd;
            rbusy[k]              = 1'b0;
         end else begin
            q[k*DATA_W +: DATA_W] = mem_q[ra_k];
            rbusy[k]              = busy[ra_k];
         end
`else
         q[k*DATA_W +: DATA_W] = mem_q[ra_k];
         rbusy[k]              = busy[ra_k];
`endif
      end
   end

   assign dbg_q = mem_q[dbg_a];

endmodule

// File: doc/regfile_nr_sb.md
Name: regfile_nr_sb

Overview:
- Parametrised successor to the CPU pipeline's 32x32 register file: configurable data width, depth and read-port count.
- Adds same-cycle write-to-read bypass, a per-register busy scoreboard for pipeline hazard detection, and an addressable debug read port in place of fixed register taps.
- Sits between the ID stage (reads, issue) and the WB stage (writes) of the pipelined CPU.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr_n  in  1  synchronous active-low reset.
- we  in  1  write enable, WB stage.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- ra  in  NUM_RD*ADDR_W  packed read addresses; port k = ra[k*ADDR_W +: ADDR_W].
- q  out  NUM_RD*DATA_W  packed read data, combinational.
- rbusy  out  NUM_RD  busy flag of each read address, combinational.
- iss_vld  in  1  an instruction issues with a destination register.
- iss_rd  in  ADDR_W  destination register of the issuing instruction.
- dbg_a  in  ADDR_W  debug read address.
- dbg_q  out  DATA_W  debug read data, combinational; never bypassed.

Behaviour:
- Reset:
  - clk rising edge with clr_n=0 clears every register and every busy bit; takes priority over we and iss_vld.
  - From the next cycle, q, rbusy and dbg_q read 0 for every address.
- Register 0:
  - Hardwired zero; writes to address 0 are ignored.
  - Reads of address 0 return 0 on q and dbg_q.
  - Busy bit 0 is never set.
- Write:
  - On a rising edge with clr_n=1, we=1 and wa!=0, reg[wa] <= wd.
  - One write per cycle.
- Read:
  - q port k = reg[ra_k], combinational, zero added latency.
  - Bypass (see optional feature): when we=1, wa!=0 and ra_k==wa in the same cycle, q_k = wd.
- Scoreboard:
  - One busy bit per register.
  - Set on the edge where iss_vld=1 and iss_rd!=0.
  - Cleared on the edge where we=1 and wa matches, unless the same edge also sets it.
  - Simultaneous issue and writeback to the same register: the bit stays set, because the new producer is pending.
  - Issue to an already-busy register: the bit remains set (no count; WAW is the issue stage's responsibility).
  - rbusy_k = busy[ra_k], except 0 when the bypass condition for port k holds in that cycle.
- Mid-operation reset: pending busy bits are discarded; no write in that cycle takes effect.
- No X propagation: addresses are always in range by construction (depth = 2**ADDR_W).

Optional Feature:
- RF_BYPASS_EN defined:
  - Write-to-read bypass on q, with busy masking as described above.
  - Required for the single-cycle-WB pipeline.
- RF_BYPASS_EN undefined:
  - q returns the pre-edge register contents.
  - rbusy reports the raw busy bit, so a read of the register written in the same cycle still shows busy=1.
  - The issue stage stalls one extra cycle.
- dbg_q is unaffected either way.

Decomposition:
- Package rf_pkg:
  - Default DATA_W, ADDR_W and NUM_RD constants.
  - REG_ZERO constant (0).
  - Typedefs for a register address and a data word.
- Sub-module regfile_sb (busy scoreboard):
  - Inputs: clk, clr_n, set/clear strobes and addresses.
  - Outputs: the busy vector.
  - The top level handles storage, read muxing and bypass.

Test Plan:
- Reset: write 0xDEADBEEF to r5, set busy r5, pulse clr_n=0 for 1 cycle -> q(r5)=0, rbusy=0, dbg_q(r5)=0.
- r0: we=1, wa=0, wd=0xFFFFFFFF; iss_vld=1, iss_rd=0 -> q(r0)=0, rbusy(r0)=0, including same-cycle bypass.
- Bypass (RF_BYPASS_EN defined): set busy r7; next cycle we=1, wa=7, wd=0x12345678, ra0=7 -> same cycle q0=0x12345678, rbusy0=0; next cycle busy r7 cleared.
- No bypass (macro undefined), same stimulus -> same-cycle q0=old value, rbusy0=1; next cycle q0=0x12345678, rbusy0=0.
- Simultaneous set and clear on r9 in one cycle -> rbusy(r9)=1 afterwards; a further write to r9 -> rbusy(r9)=0.
- NUM_RD=4, DATA_W=16: write distinct values to r1..r4, read all four ports plus dbg_a=3 -> every port returns its value; dbg_q equals the r3 value.
